bus_responder: RTL
==================

BUS_RESPONDER -- requirements
Module: bus_responder

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, meaning the word address width.
REQ-002 The block SHALL have parameter DATA_W, default 32, meaning the data word width.
REQ-003 The block SHALL have parameter MAX_BURST, default 16, meaning the maximum number of consecutive accesses by one owner while the other requester is waiting.
REQ-004 The block SHALL have these ports:
- Clk, input, 1: the single clock; all logic on the rising edge.
- reset, input, 1: synchronous, active-high reset.
- M_req, input, 1: DMAC master bus request.
- M_wr, input, 1: DMAC access type; 1 = write, 0 = read.
- M_address, input, ADDR_W: DMAC word address.
- M_dout, input, DATA_W: DMAC write data.
- M_grant, output, 1: bus granted to the DMAC.
- M_din, output, DATA_W: read data returned to the DMAC.
- H_req, H_wr, H_address, H_dout, inputs, same widths and meaning as the M_ inputs, for the host requester.
- H_grant, H_din, outputs, same widths and meaning as the M_ outputs, for the host requester.

Function
REQ-005 The block SHALL contain a 2^ADDR_W x DATA_W word memory shared by both requesters.
REQ-006 The arbiter SHALL have exactly three states, IDLE, OWN_M and OWN_H; M_grant = (state == OWN_M) and H_grant = (state == OWN_H), both registered.
REQ-007 In IDLE, at a clock edge:
- One request high: the next state is that requester's OWN state.
- Both requests high: the next state goes to the requester that was not the last owner (round-robin).
- Neither request high: the block stays in IDLE.
REQ-008 In OWN_x, if x_req is low at the edge, the next state SHALL be IDLE, and no access occurs on that edge.
REQ-009 An access SHALL occur on every edge where x_grant and x_req are both high.
REQ-010 A write access SHALL store x_dout at x_address on that edge.
REQ-011 A read access SHALL load the word at x_address into x_din on that edge, so read data is valid exactly one cycle after the address is sampled.
REQ-012 A read of the address written on the previous edge SHALL return the new data.
REQ-013 x_din SHALL hold its last read value when no read occurs; the non-owner's address, data and wr inputs SHALL be ignored.
REQ-014 A burst counter SHALL count the owner's accesses, clear on every entry to IDLE, and saturate at MAX_BURST.
REQ-015 When the counter reaches MAX_BURST while the other requester's req is high, the next state SHALL be IDLE, so that round-robin hands the bus to the waiting requester.
REQ-016 If the other requester is idle, the owner SHALL keep the grant without limit.
REQ-017 A grant SHALL never be asserted to both requesters in the same cycle, and there SHALL be at least one IDLE cycle between owners.
REQ-018 Addresses SHALL wrap naturally modulo 2^ADDR_W; no out-of-range condition exists.

Reset
REQ-019 While reset is high at an edge, the block SHALL enter IDLE, with M_grant = H_grant = 0, M_din = H_din = 0 and the burst counter = 0.
REQ-020 Reset SHALL set the last owner to H, so that M wins the first tie.
REQ-021 Reset SHALL block any memory write on that edge.
REQ-022 Memory contents SHALL NOT be cleared by reset.
REQ-023 Reset asserted mid-burst SHALL drop the grant in the following cycle with no further access.

Structure
REQ-024 The state encoding, the ADDR_W/DATA_W/MAX_BURST defaults and the access-type constants (WR = 1, RD = 0) SHALL reside in a shared package, bus_pkg.
REQ-025 The memory SHALL be a single sub-module, bus_ram, providing one synchronous write port and one registered read port.
REQ-026 The arbiter, the burst counter and the read-data steering SHALL stay in bus_responder.

Verification
REQ-027 Scenario: reset, then M_req = 1, M_wr = 1, address 0x10, data 0xDEADBEEF -> M_grant rises 1 cycle after M_req, and mem[0x10] = 0xDEADBEEF after the first granted edge.
REQ-028 Scenario: M reads 0x10 while granted -> M_din = 0xDEADBEEF one cycle later; H_din stays 0.
REQ-029 Scenario: M_req and H_req both asserted in the same cycle directly after reset -> M granted first; after M drops its request, one IDLE cycle, then H granted.
REQ-030 Scenario: M holds its request for 40 writes to 0x00..0x27 while H_req = 1 -> M_grant drops after exactly 16 accesses, H owns after one IDLE cycle, and M regains the bus once H releases.
REQ-031 Scenario: H writes 0x5A5A5A5A to 0xFF, then reads 0xFF on the next edge -> H_din = 0x5A5A5A5A, and writing to 0xFF+1 wraps to address 0x00.
REQ-032 Scenario: reset asserted during an M write burst -> M_grant = 0 on the next cycle, the memory word targeted on the reset edge is unchanged, and M_din = 0.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared definitions for the two-requester bus responder: arbiter states,
// default geometry and access-type encoding.
package bus_pkg;

    localparam int unsigned ADDR_W_DEF    = 8;
    localparam int unsigned DATA_W_DEF    = 32;
    localparam int unsigned MAX_BURST_DEF = 16;

    localparam logic ACC_WR = 1'b1;
    localparam logic ACC_RD = 1'b0;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StOwnM = 2'd1,
        StOwnH = 2'd2
    } bus_state_e;

endpackage

// File: rtl/bus_ram.sv
// Shared word memory: one synchronous write port and one registered read port.
// Contents have no reset.
module bus_ram #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/bus_responder.sv
// Round-robin arbiter between DMAC (M) and host (H) in front of a shared memory,
// with a burst limit that applies only while the other requester is waiting.
module bus_responder
    import bus_pkg::*;
#(
    parameter int unsigned ADDR_W    = ADDR_W_DEF,
    parameter int unsigned DATA_W    = DATA_W_DEF,
    parameter int unsigned MAX_BURST = MAX_BURST_DEF
) (
    input  logic              Clk,
    input  logic              reset,
    input  logic              M_req,
    input  logic              M_wr,
    input  logic [ADDR_W-1:0] M_address,
    input  logic [DATA_W-1:0] M_dout,
    output logic              M_grant,
    output logic [DATA_W-1:0] M_din,
    input  logic              H_req,
    input  logic              H_wr,
    input  logic [ADDR_W-1:0] H_address,
    input  logic [DATA_W-1:0] H_dout,
    output logic              H_grant,
    output logic [DATA_W-1:0] H_din
);

    localparam int unsigned CntW = $clog2(MAX_BURST + 1);

    bus_state_e        state_q, state_d;
    logic              last_m_q, last_m_d;
    logic [CntW-1:0]   burst_q, burst_d;
    logic              m_rd_q, h_rd_q;
    logic [DATA_W-1:0] m_hold_q, h_hold_q;

    logic              access_m, access_h, access;
    logic              acc_wr;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_data;
    logic [DATA_W-1:0] ram_rdata;

    assign access_m = (state_q == StOwnM) && M_req;
    assign access_h = (state_q == StOwnH) && H_req;
    assign access   = access_m || access_h;
    assign acc_wr   = access_m ? M_wr      : H_wr;
    assign acc_addr = access_m ? M_address : H_address;
    assign acc_data = access_m ? M_dout    : H_dout;

    always_comb begin
        state_d  = state_q;
        last_m_d = last_m_q;
        burst_d  = burst_q;
        unique case (state_q)
            StIdle: begin
                if (M_req && (!H_req || !last_m_q)) begin
                    state_d  = StOwnM;
                    last_m_d = 1'b1;
                end else if (H_req) begin
                    state_d  = StOwnH;
                    last_m_d = 1'b0;
                end
            end
            StOwnM, StOwnH: begin
                if (!access) begin
                    state_d = StIdle;
                end else begin
                    if (burst_q != CntW'(MAX_BURST)) begin
                        burst_d = burst_q + CntW'(1);
                    end
                    // This access is the MAX_BURST-th (or later): yield to a waiter.
                    if ((access_m ? H_req : M_req) && burst_q >= CntW'(MAX_BURST - 1)) begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        if (state_d == StIdle) begin
            burst_d = '0;
        end
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            state_q  <= StIdle;
            last_m_q <= 1'b0;
            burst_q  <= '0;
            m_rd_q   <= 1'b0;
            h_rd_q   <= 1'b0;
            m_hold_q <= '0;
            h_hold_q <= '0;
        end else begin
            state_q  <= state_d;
            last_m_q <= last_m_d;
            burst_q  <= burst_d;
            m_rd_q   <= access_m && (M_wr == ACC_RD);
            h_rd_q   <= access_h && (H_wr == ACC_RD);
            m_hold_q <= M_din;
            h_hold_q <= H_din;
        end
    end

    bus_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk_i   (Clk),
        .we_i    (access && (acc_wr == ACC_WR) && !reset),
        .waddr_i (acc_addr),
        .wdata_i (acc_data),
        .re_i    (access && (acc_wr == ACC_RD)),
        .raddr_i (acc_addr),
        .rdata_o (ram_rdata)
    );

    // Fresh read data is steered to the reader for one cycle, then held.
    assign M_din   = m_rd_q ? ram_rdata : m_hold_q;
    assign H_din   = h_rd_q ? ram_rdata : h_hold_q;
    assign M_grant = (state_q == StOwnM);
    assign H_grant = (state_q == StOwnH);

endmodule
